mdu_ctrl: RTL and testbench
===========================

MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width; only 64 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  the EXU presents an M-extension op.
REQ-005 SHALL have port req_ready  output  1  the controller can accept an op.
REQ-006 SHALL have port alu_op  input  7  op code: bit6 = W, bits[4:3] = 2'b11 for M ops, bits[2:0] = mul/mulh/mulhsu/mulhu/div/divu/rem/remu (000..111).
REQ-007 SHALL have ports in0 and in1  input  64 each  rs1 and rs2 operands.
REQ-008 SHALL have port flush  input  1  pipeline flush.
REQ-009 SHALL have ports resp_valid  output  1 and resp_ready  input  1  result handshake.
REQ-010 SHALL have port resp_data  output  64  result.
REQ-011 SHALL have ports mul_valid  output  1, mul_ready  input  1, mul_flush  output  1, mulw  output  1, mul_signed  output  2, multiplicand  output  64, multiplier  output  64  for the external multiplier.
REQ-012 SHALL have ports mul_out_valid  input  1, mul_hi  input  64, mul_lo  input  64  for multiplier results.

Function
REQ-013 SHALL implement states IDLE, MUL_REQ, MUL_WAIT, DIV_RUN, DONE; req_ready = (state == IDLE).
REQ-014 SHALL accept an op on req_valid && req_ready && !flush, latching alu_op and operands; W ops use the zero-extended low 32 bits.
REQ-015 Multiply ops: IDLE -> MUL_REQ; mul_valid high in MUL_REQ until mul_ready, then -> MUL_WAIT; capture mul_hi/mul_lo on mul_out_valid, then -> DONE.
REQ-016 SHALL drive mul_signed = 11 for mul/mulh, 10 for mulhsu, 00 for mulhu, and mulw = latched bit6; multiplicand and multiplier held stable from accept until capture.
REQ-017 SHALL select mul -> lo and mulh/mulhsu/mulhu -> hi.
REQ-018 Divide ops with divisor == 0 SHALL go IDLE -> DONE with quotient all-ones and remainder = dividend.
REQ-019 Signed divide with dividend = most-negative (64- or 32-bit per W) and divisor = -1 SHALL go IDLE -> DONE with quotient = dividend and remainder = 0.
REQ-020 Other divides SHALL go to DIV_RUN and use an internal restoring divider on absolute values, one quotient bit per cycle, for N = 64 cycles (N = 32 when W).
REQ-021 Divider signs: quotient negated iff signed and operand signs differ; remainder takes the dividend's sign.
REQ-022 Latency from the accept cycle T: special-case divides give resp_valid at T+1; normal divides give resp_valid at T+N+1.
REQ-023 W results SHALL be sign-extended from bit 31 into resp_data[63:32].
REQ-024 A non-M alu_op accepted in IDLE SHALL go to DONE with resp_data = 0.
REQ-025 In DONE, resp_valid = 1 and resp_data SHALL hold stable until resp_ready, then -> IDLE; no new op is accepted in that same cycle.
REQ-026 flush in any state SHALL force IDLE next cycle, clear resp_valid and mul_valid, discard the result, and pulse mul_flush for 1 cycle if the state was MUL_REQ or MUL_WAIT.
REQ-027 flush SHALL take priority over resp_ready and over a simultaneous req_valid.
REQ-028 mul_out_valid outside MUL_WAIT SHALL be ignored.

Reset
REQ-029 While rst_n is low: state = IDLE, req_ready = 1, resp_valid = 0, resp_data = 0, mul_valid = 0, mul_flush = 0, divider counter = 0.
REQ-030 Reset asserted mid-operation SHALL abandon the op; no response is issued after release.

Verification
REQ-031 div, in0 = 0xFFFF_FFFF_FFFF_FFF9, in1 = 2 -> resp_data 0xFFFF_FFFF_FFFF_FFFD at T+65; rem with the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-032 divu, in0 = 5, in1 = 0 -> 0xFFFF_FFFF_FFFF_FFFF at T+1; remu with the same operands -> 5 at T+1.
REQ-033 divw (alu_op = 7'b1011100), in0 = 0x8000_0000, in1 = 0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 at T+1; remw -> 0.
REQ-034 mulhu against a multiplier stub (mul_ready after 2 cycles, hi = 1, lo = 0x8000_0000) -> mul_signed = 00 and resp_data = 1; mulw with the same stub -> 0xFFFF_FFFF_8000_0000.
REQ-035 flush on the 10th DIV_RUN cycle -> IDLE and req_ready = 1 next cycle, resp_valid never rises; the next divu 10/3 returns 3.
REQ-036 resp_ready held low for 5 cycles in DONE -> resp_valid and resp_data stable throughout; IDLE one cycle after resp_ready rises.

Source files
------------

// File: rtl/mdu_ctrl_if.sv
// Handshake and data bundle between the EXU, the M-extension controller and
// the external multiplier. The controller sits on the slave side; the
// environment (EXU plus multiplier) sits on the master side.
interface mdu_ctrl_if #(
  parameter int XLEN = 64
);
  // EXU request
  logic            req_valid;
  logic            req_ready;
  logic [6:0]      alu_op;
  logic [XLEN-1:0] in0;
  logic [XLEN-1:0] in1;
  logic            flush;
  // EXU response
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  // external multiplier
  logic            mul_valid;
  logic            mul_ready;
  logic            mul_flush;
  logic            mulw;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            mul_out_valid;
  logic [XLEN-1:0] mul_hi;
  logic [XLEN-1:0] mul_lo;

  modport slave (
    input  req_valid, alu_op, in0, in1, flush, resp_ready,
           mul_ready, mul_out_valid, mul_hi, mul_lo,
    output req_ready, resp_valid, resp_data,
           mul_valid, mul_flush, mulw, mul_signed, multiplicand, multiplier
  );

  modport master (
    output req_valid, alu_op, in0, in1, flush, resp_ready,
           mul_ready, mul_out_valid, mul_hi, mul_lo,
    input  req_ready, resp_valid, resp_data,
           mul_valid, mul_flush, mulw, mul_signed, multiplicand, multiplier
  );
endinterface

// File: rtl/mdu_ctrl.sv
// M-extension controller: sequences multiplies through an external
// multiplier and runs divides on an internal restoring divider (one
// quotient bit per cycle). Division-by-zero and signed overflow are
// resolved at accept time and answer one cycle later.
module mdu_ctrl #(
  parameter int XLEN = 64
) (
  input logic       clk,
  input logic       rst_n,
  mdu_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_DIV_RUN,
    S_DONE
  } state_e;

  localparam logic [XLEN-1:0] MIN_D = 64'h8000_0000_0000_0000;
  localparam logic [XLEN-1:0] MIN_W = 64'h0000_0000_8000_0000;

  state_e          state_q, state_d;
  logic            w_q, w_d;                 // latched W bit
  logic [1:0]      fn_q, fn_d;               // latched alu_op[1:0]
  logic            neg_quo_q, neg_quo_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] a_q, a_d;                 // multiplicand / dividend-quotient shifter
  logic [XLEN-1:0] b_q, b_d;                 // multiplier / |divisor|
  logic [XLEN-1:0] rem_q, rem_d;             // partial remainder
  logic [XLEN-1:0] resp_data_q, resp_data_d;
  logic [6:0]      cnt_q, cnt_d;             // divide steps left

  // alu_op[5] carries no meaning for this unit.
  logic alu_op_unused;
  assign alu_op_unused = bus.alu_op[5];

  function automatic logic [XLEN-1:0] narrow(input logic [XLEN-1:0] v, input logic w);
    return w ? {32'b0, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + 64'd1;
  endfunction

  // Decode of the op presented on the request side, including the two
  // divide corner cases that bypass the iterative divider.
  logic            in_w, in_m, in_div, in_signed, in_rem, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [2:0]      in_f;
  logic [XLEN-1:0] opa, opb, a_abs, b_abs, special_res;
  always_comb begin
    in_w      = bus.alu_op[6];
    in_f      = bus.alu_op[2:0];
    in_m      = (bus.alu_op[4:3] == 2'b11);
    in_div    = in_f[2];
    in_signed = in_div && !in_f[0];
    in_rem    = in_f[1];
    opa       = narrow(bus.in0, in_w);
    opb       = narrow(bus.in1, in_w);
    a_neg     = in_signed && (in_w ? opa[31] : opa[63]);
    b_neg     = in_signed && (in_w ? opb[31] : opb[63]);
    a_abs     = a_neg ? narrow(negate(opa), in_w) : opa;
    b_abs     = b_neg ? narrow(negate(opb), in_w) : opb;
    div_zero  = (opb == '0);
    div_ovf   = in_signed && (opb == narrow('1, in_w)) && (opa == (in_w ? MIN_W : MIN_D));
    if (div_zero) special_res = in_rem ? opa : '1;
    else          special_res = in_rem ? '0  : opa;
    special_res = sext_w(special_res, in_w);
  end

  // One restoring-division step plus sign fix-up of the final result.
  logic [XLEN:0]   part;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx, quo_fin, rem_fin, div_res, mul_res;
  always_comb begin
    part    = {rem_q, a_q[XLEN-1]};
    ge      = (part >= {1'b0, b_q});
    rem_nx  = ge ? (part[XLEN-1:0] - b_q) : part[XLEN-1:0];
    quo_nx  = {a_q[XLEN-2:0], ge};
    quo_fin = neg_quo_q ? negate(quo_nx) : quo_nx;
    rem_fin = neg_rem_q ? negate(rem_nx) : rem_nx;
    div_res = sext_w(fn_q[1] ? rem_fin : quo_fin, w_q);
    mul_res = sext_w((fn_q == 2'b00) ? bus.mul_lo : bus.mul_hi, w_q);
  end

  // Next-state and datapath updates; flush overrides everything.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d     = state_q;
    w_d         = w_q;
    fn_d        = fn_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    a_d         = a_q;
    b_d         = b_q;
    rem_d       = rem_q;
    resp_data_d = resp_data_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && !bus.flush) begin
          w_d       = in_w;
          fn_d      = in_f[1:0];
          neg_quo_d = in_signed && (a_neg ^ b_neg);
          neg_rem_d = a_neg;
          a_d       = opa;
          b_d       = opb;
          rem_d     = '0;
          if (!in_m) begin
            resp_data_d = '0;
            state_d     = S_DONE;
          end else if (!in_div) begin
            state_d = S_MUL_REQ;
          end else if (div_zero || div_ovf) begin
            resp_data_d = special_res;
            state_d     = S_DONE;
          end else begin
            a_d     = in_w ? {a_abs[31:0], 32'b0} : a_abs;
            b_d     = b_abs;
            cnt_d   = in_w ? 7'd32 : 7'd64;
            state_d = S_DIV_RUN;
          end
        end
      end
      S_MUL_REQ: begin
        if (bus.mul_ready) state_d = S_MUL_WAIT;
      end
      S_MUL_WAIT: begin
        if (bus.mul_out_valid) begin
          resp_data_d = mul_res;
          state_d     = S_DONE;
        end
      end
      S_DIV_RUN: begin
        a_d   = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q - 7'd1;
        if (cnt_q == 7'd1) begin
          resp_data_d = div_res;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      resp_data_d = resp_data_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      w_q         <= 1'b0;
      fn_q        <= 2'b00;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      rem_q       <= '0;
      resp_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      w_q         <= w_d;
      fn_q        <= fn_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rem_q       <= rem_d;
      resp_data_q <= resp_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.resp_valid   = (state_q == S_DONE);
  assign bus.resp_data    = resp_data_q;
  assign bus.mul_valid    = (state_q == S_MUL_REQ);
  assign bus.mul_flush    = bus.flush && ((state_q == S_MUL_REQ) || (state_q == S_MUL_WAIT));
  assign bus.mulw         = w_q;
  assign bus.mul_signed   = !fn_q[1] ? 2'b11 : (fn_q[0] ? 2'b00 : 2'b10);
  assign bus.multiplicand = a_q;
  assign bus.multiplier   = b_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases, randomized
// divides and multiplies against a behavioural model, flush and reset.
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_ctrl_if #(.XLEN(64)) bus ();
  mdu_ctrl #(.XLEN(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [63:0] stub_hi = '0, stub_lo = '0;
  logic [63:0] cap_mcand_r, cap_mplier_r, cap_mcand_o, cap_mplier_o;
  logic [1:0]  cap_sign_r;
  logic        cap_mulw_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic bit ref_special(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b);
    logic sgn;
    sgn = !op[0];
    if (op[6]) return (b[31:0] == 0) || (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return (b == 0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  function automatic logic [63:0] ref_div(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b);
    logic sgn, rem;
    logic [31:0] x, y, r32;
    int sx, sy;
    longint lx, ly;
    logic [63:0] r;
    sgn = !op[0];
    rem = op[1];
    if (op[6]) begin
      x = a[31:0]; y = b[31:0]; sx = x; sy = y;
      if (y == 0)                                          r32 = rem ? x : 32'hFFFF_FFFF;
      else if (sgn && x == 32'h8000_0000 && y == '1)       r32 = rem ? 32'd0 : x;
      else if (sgn)                                        r32 = rem ? 32'(sx % sy) : 32'(sx / sy);
      else                                                 r32 = rem ? x % y : x / y;
      r = {{32{r32[31]}}, r32};
    end else begin
      lx = a; ly = b;
      if (b == 0)                                          r = rem ? a : '1;
      else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) r = rem ? 64'd0 : a;
      else if (sgn)                                        r = rem ? 64'(lx % ly) : 64'(lx / ly);
      else                                                 r = rem ? a % b : a / b;
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[4:3] != 2'b11) return 1;
    if (ref_special(op, a, b)) return 1;
    return op[6] ? 33 : 65;
  endfunction

  // ---------------- multiplier stub ----------------
  // Raises mul_ready on the 2nd cycle of mul_valid, returns stub_hi/lo one
  // cycle later, and drives junk mul_out_valid pulses while still in MUL_REQ.
  initial begin : mul_stub
    int  seen;
    bit  give;
    seen = 0;
    give = 0;
    forever begin
      @(posedge clk); #1;
      bus.mul_ready     = 1'b0;
      bus.mul_out_valid = 1'b0;
      bus.mul_hi        = 64'hDEAD_BEEF_DEAD_BEEF;
      bus.mul_lo        = 64'hBAD0_BAD0_BAD0_BAD0;
      if (give) begin
        give = 0;
        seen = 0;
        bus.mul_out_valid = 1'b1;
        bus.mul_hi        = stub_hi;
        bus.mul_lo        = stub_lo;
        cap_mcand_o       = bus.multiplicand;
        cap_mplier_o      = bus.multiplier;
      end else if (bus.mul_valid) begin
        seen++;
        if (seen >= 2) begin
          bus.mul_ready = 1'b1;
          give          = 1;
          cap_mcand_r   = bus.multiplicand;
          cap_mplier_r  = bus.multiplier;
          cap_sign_r    = bus.mul_signed;
          cap_mulw_r    = bus.mulw;
        end else begin
          bus.mul_out_valid = 1'b1;
        end
      end else begin
        seen = 0;
      end
    end
  end

  // Issue one op from IDLE, time the response, optionally stall resp_ready.
  task automatic run_op(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b,
                        input int hold, output logic [63:0] data, output int lat);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    check("req_ready_before_op", bus.req_ready, 1);
    bus.alu_op = op; bus.in0 = a; bus.in1 = b; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.alu_op = 7'h00; bus.in0 = ~a; bus.in1 = ~b;
    lat = 1;
    while (!bus.resp_valid && lat < 300) begin @(posedge clk); #1; lat++; end
    data = bus.resp_data;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.resp_valid, 1);
      check("hold_data", bus.resp_data, data);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check("idle_after_resp", bus.req_ready, 1);
    check("valid_after_resp", bus.resp_valid, 0);
  endtask

  task automatic exec(input string tag, input logic [6:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp, input int exp_lat, input int hold);
    logic [63:0] d;
    int lat;
    run_op(op, a, b, hold, d, lat);
    check({tag, "_timeout"}, 64'(lat >= 300), 0);
    check({tag, "_data"}, d, exp);
    if (exp_lat >= 0) check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin : main
    logic [63:0] a, b, exp_a, exp_b;
    logic [6:0]  op;
    logic        w;
    logic [1:0]  f;
    int          mode, bad;

    bus.req_valid = 1'b1; bus.alu_op = 7'b0011101; bus.in0 = 64'd5; bus.in1 = 64'd0;
    bus.flush = 1'b0; bus.resp_ready = 1'b0;
    bus.mul_ready = 1'b0; bus.mul_out_valid = 1'b0; bus.mul_hi = '0; bus.mul_lo = '0;

    // Reset values while rst_n is low, even with a request pending.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_mul_valid", bus.mul_valid, 0);
    check("rst_mul_flush", bus.mul_flush, 0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", bus.resp_valid, 0);

    // Directed divide corner cases.
    exec("div_neg7_2", 7'b0011100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
    exec("rem_neg7_2", 7'b0011110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
    exec("divu_by0",   7'b0011101, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
    exec("remu_by0",   7'b0011111, 64'd5, 64'd0, 64'd5, 1, 0);
    exec("divw_ovf",   7'b1011100, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 0);
    exec("remw_ovf",   7'b1011110, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1, 0);
    exec("div_ovf64",  7'b0011100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 0);
    exec("divw_norm",  7'b1011100, 64'hABCD_0000_FFFF_FFF9, 64'h1234_0000_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 33, 0);

    // Multiplier stub scenarios.
    stub_hi = 64'd1; stub_lo = 64'h8000_0000;
    exec("mulhu_stub", 7'b0011011, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'd1, -1, 0);
    check("mulhu_signed", cap_sign_r, 2'b00);
    check("mulhu_mcand", cap_mcand_o, 64'h1234_5678_9ABC_DEF0);
    exec("mulw_stub", 7'b1011000, 64'hFFFF_0000_0000_0003, 64'hAAAA_0000_0000_0005, 64'hFFFF_FFFF_8000_0000, -1, 0);
    check("mulw_flag", cap_mulw_r, 1);
    check("mulw_mcand", cap_mcand_r, 64'h3);
    check("mulw_mplier", cap_mplier_r, 64'h5);

    // Non-M ops answer zero one cycle after accept.
    exec("nonm_a", 7'b0000101, 64'd77, 64'd3, 64'd0, 1, 0);
    exec("nonm_b", 7'b0010100, 64'd77, 64'd3, 64'd0, 1, 0);

    // Response held while resp_ready stays low.
    exec("divu_hold", 7'b0011101, 64'd100, 64'd7, 64'd14, 65, 5);

    // Flush on the 10th DIV_RUN cycle.
    bus.alu_op = 7'b0011101; bus.in0 = 64'd1000; bus.in1 = 64'd7; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    check("div_run_busy", bus.req_ready, 0);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_div_ready", bus.req_ready, 1);
    bad = 0;
    repeat (70) begin @(posedge clk); #1; if (bus.resp_valid) bad++; end
    check("flush_div_no_resp", 64'(bad), 0);
    exec("divu_after_flush", 7'b0011101, 64'd10, 64'd3, 64'd3, 65, 0);

    // Flush while in MUL_REQ pulses mul_flush.
    bus.alu_op = 7'b0011000; bus.in0 = 64'd9; bus.in1 = 64'd9; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("mul_req_valid", bus.mul_valid, 1);
    bus.flush = 1'b1;
    #1;
    check("mul_flush_pulse", bus.mul_flush, 1);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("mul_flush_clear", bus.mul_flush, 0);
    check("mul_valid_clear", bus.mul_valid, 0);
    check("mul_flush_ready", bus.req_ready, 1);

    // Flush beats a simultaneous request in IDLE.
    bus.alu_op = 7'b0011101; bus.in0 = 64'd5; bus.in1 = 64'd0;
    bus.req_valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.flush = 1'b0;
    check("flush_blocks_req", bus.resp_valid, 0);

    // Flush beats resp_ready in DONE.
    bus.alu_op = 7'b0000000; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("done_valid", bus.resp_valid, 1);
    bus.flush = 1'b1; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.resp_ready = 1'b0;
    check("flush_done_ready", bus.req_ready, 1);
    check("flush_done_valid", bus.resp_valid, 0);

    // Randomized divides.
    for (int i = 0; i < 24; i++) begin
      op = {1'($urandom_range(0, 1)), 1'b0, 2'b11, 1'b1, 2'($urandom_range(0, 3))};
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      mode = $urandom_range(0, 5);
      if (mode == 0) b = op[6] ? {$urandom, 32'h0} : 64'd0;
      else if (mode == 1) begin
        a = op[6] ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = op[6] ? {$urandom, 32'hFFFF_FFFF} : '1;
      end
      else if (mode == 2) b = b >> $urandom_range(20, 60);
      else if (mode == 3) a = a >> $urandom_range(0, 40);
      if (b == 0 && mode != 0) b = 64'd3;
      exec("rand_div", op, a, b, ref_div(op, a, b), ref_lat(op, a, b), 0);
    end

    // Randomized multiplies through the stub.
    for (int i = 0; i < 10; i++) begin
      f = 2'($urandom_range(0, 3));
      w = (f == 2'b00) ? 1'($urandom_range(0, 1)) : 1'b0;
      op = {w, 1'b0, 2'b11, 1'b0, f};
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      stub_hi = {$urandom, $urandom};
      stub_lo = {$urandom, $urandom};
      exp_a = w ? {32'b0, a[31:0]} : a;
      exp_b = w ? {32'b0, b[31:0]} : b;
      exec("rand_mul", op, a, b,
           (f == 2'b00) ? (w ? {{32{stub_lo[31]}}, stub_lo[31:0]} : stub_lo) : stub_hi, -1, 0);
      check("rand_mul_signed", cap_sign_r, (f[1] == 1'b0) ? 2'b11 : (f[0] ? 2'b00 : 2'b10));
      check("rand_mulw", cap_mulw_r, w);
      check("rand_mcand", cap_mcand_r, exp_a);
      check("rand_mplier", cap_mplier_r, exp_b);
      check("rand_mcand_stable", cap_mcand_o, exp_a);
      check("rand_mplier_stable", cap_mplier_o, exp_b);
    end

    // Reset in the middle of a divide abandons it.
    bus.alu_op = 7'b0011100; bus.in0 = 64'd12345; bus.in1 = 64'd11; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    check("midrst_ready", bus.req_ready, 1);
    check("midrst_valid", bus.resp_valid, 0);
    check("midrst_data", bus.resp_data, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (80) begin @(posedge clk); #1; if (bus.resp_valid) bad++; end
    check("midrst_no_resp", 64'(bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
